// File: rtl/output_buffer.sv
// Result buffer between the accumulator and the host read-back path: 16 x 32-bit
// entries filled by the accumulator and drained in address order over a valid/ready stream.
module output_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain_start,
    input  logic [ADDR_W-1:0] drain_base,
    input  logic [ADDR_W:0]   drain_count,
    input  logic              drain_abort,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              overwrite_err,
    output logic [DEPTH-1:0]  entry_valid
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              hs;
    logic [DEPTH-1:0]  valid_next;

    // Abort outranks the handshake, so an aborted word keeps its valid flag.
    assign hs = (state == S_SEND) && rd_valid && rd_ready && !drain_abort;

    // A store in the same cycle as the handshake on that entry wins.
    always_comb begin
        valid_next = entry_valid;
        if (hs)
            valid_next[ptr] = 1'b0;
        if (wr_en)
            valid_next[wr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_valid   <= '0;
            overwrite_err <= 1'b0;
        end else begin
            entry_valid   <= valid_next;
            overwrite_err <= wr_en && entry_valid[wr_addr] && !(hs && (ptr == wr_addr));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_addr   <= '0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (drain_start) begin
                        ptr       <= drain_base;
                        remaining <= (drain_count == '0) ? FULL_CNT : drain_count;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (drain_abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (entry_valid[ptr]) begin
                        rd_data  <= mem[ptr];
                        rd_addr  <= ptr;
                        rd_last  <= (remaining == ONE_CNT);
                        rd_valid <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (drain_abort) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        rd_last   <= 1'b0;
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - ONE_CNT;
                        if (remaining == ONE_CNT) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: stimulus pushes expected drain words, a
// negedge monitor pops them on each handshake and tracks store/valid/overwrite rules.
module tb_output_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              drain_start = 1'b0;
    logic [ADDR_W-1:0] drain_base = '0;
    logic [ADDR_W:0]   drain_count = '0;
    logic              drain_abort = 1'b0;
    logic              rd_valid;
    logic              rd_ready = 1'b1;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              busy;
    logic              done;
    logic              overwrite_err;
    logic [DEPTH-1:0]  entry_valid;

    output_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .drain_start(drain_start), .drain_base(drain_base), .drain_count(drain_count),
        .drain_abort(drain_abort), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_last(rd_last), .busy(busy),
        .done(done), .overwrite_err(overwrite_err), .entry_valid(entry_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        logic              l;
    } item_t;

    item_t             sb[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DEPTH-1:0]  model_valid = '0;
    logic              exp_ow = 1'b0;
    logic              exp_done = 1'b0;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares per-cycle flags and pops the scoreboard on each accepted word.
    always @(negedge clk) begin
        item_t it;
        logic  hs;
        if (!rst) begin
            model_valid = '0;
            sb.delete();
            exp_ow   = 1'b0;
            exp_done = 1'b0;
        end else begin
            chk("overwrite_err", overwrite_err, exp_ow);
            chk("done", done, exp_done);
            chk("entry_valid", entry_valid, model_valid);
            hs = rd_valid && rd_ready && !drain_abort;
            exp_done = 1'b0;
            if (hs) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    it = sb.pop_front();
                    chk("rd_data", rd_data, it.d);
                    chk("rd_addr", rd_addr, it.a);
                    chk("rd_last", rd_last, it.l);
                    exp_done = it.l;
                end
            end
            exp_ow = wr_en && model_valid[wr_addr] && !(hs && rd_addr == wr_addr);
            if (hs)
                model_valid[rd_addr] = 1'b0;
            if (wr_en)
                model_valid[wr_addr] = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        ref_mem[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic start(input int base, input int cnt, input int npush);
        int n;
        item_t it;
        n = (cnt == 0) ? DEPTH : cnt;
        for (int i = 0; i < npush; i++) begin
            it.a = ADDR_W'((base + i) % DEPTH);
            it.d = ref_mem[it.a];
            it.l = (i == n - 1);
            sb.push_back(it);
        end
        drain_start = 1'b1;
        drain_base  = ADDR_W'(base);
        drain_count = (ADDR_W+1)'(cnt);
        step();
        drain_start = 1'b0;
    endtask

    task automatic wait_drained(input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            step();
            k++;
        end
        chk("drain_timeout", sb.size() == 0, 1);
    endtask

    task automatic wait_valid(input int limit);
        int k = 0;
        while (!rd_valid && k < limit) begin
            step();
            k++;
        end
        chk("valid_timeout", rd_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] held;
        item_t it;
        int base, cnt, n, off;

        // Reset state
        #12;
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_entry_valid", entry_valid, 0);
        rst = 1'b1;
        step();

        // Asynchronous reset mid-SEND
        wr(9, 32'h9999_0009);
        rd_ready = 1'b0;
        start(9, 1, 1);
        wait_valid(10);
        #2 rst = 1'b0;
        #1;
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_rd_addr", rd_addr, 0);
        chk("arst_entry_valid", entry_valid, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        rd_ready = 1'b1;
        step();
        chk("post_rst_entry_valid", entry_valid, 0);
        chk("post_rst_rd_valid", rd_valid, 0);

        // Store then drain
        wr(2, 32'h11);
        wr(3, 32'h22);
        wr(4, 32'h33);
        start(2, 3, 3);
        chk("busy_after_start", busy, 1);
        wait_drained(30);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_4_2", entry_valid[4:2], 0);
        step();

        // Wrap and backpressure, with a rewrite of the held entry
        wr(14, 32'hE14);
        wr(15, 32'hF15);
        wr(0, 32'h000);
        rd_ready = 1'b0;
        start(14, 3, 3);
        wait_valid(10);
        held = ref_mem[14];
        for (int i = 0; i < 5; i++) begin
            chk("hold_rd_data", rd_data, held);
            chk("hold_rd_addr", rd_addr, 14);
            chk("hold_rd_valid", rd_valid, 1);
            if (i == 2)
                wr(14, 32'hDEAD);
            else
                step();
        end
        rd_ready = 1'b1;
        wait_drained(30);
        chk("wrap_busy", busy, 0);
        step();

        // Early drain stall on an empty entry
        start(5, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_rd_valid", rd_valid, 0);
            chk("stall_busy", busy, 1);
            step();
        end
        it.d = 32'hABCD;
        it.a = 5;
        it.l = 1'b1;
        sb.push_back(it);
        wr(5, 32'hABCD);
        chk("fetch_latency_early", rd_valid, 0);
        step();
        chk("fetch_latency", rd_valid, 1);
        chk("fetch_data", rd_data, 32'hABCD);
        wait_drained(10);
        step();

        // Overwrite and handshake collision
        wr(7, 32'h7A);
        wr(7, 32'h7B);
        chk("overwrite_pulse", overwrite_err, 1);
        rd_ready = 1'b0;
        start(7, 1, 1);
        wait_valid(10);
        rd_ready = 1'b1;
        wr(7, 32'h7C);
        chk("collision_valid7", entry_valid[7], 1);
        chk("collision_no_err", overwrite_err, 0);
        step();
        chk("collision_busy", busy, 0);

        // Full drain (count 0) aborted after four words, then restarted
        for (int i = 0; i < DEPTH; i++)
            wr(ADDR_W'(i), $urandom);
        start(0, 0, 4);
        wait_drained(40);
        drain_abort = 1'b1;
        step();
        drain_abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_valid_map", entry_valid, 16'hFFF0);
        step();
        start(4, 0, 12);
        wait_drained(100);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tail_stall_rd_valid", rd_valid, 0);
            chk("tail_stall_busy", busy, 1);
        end
        for (int i = 0; i < 4; i++) begin
            it.d = 32'hC0DE_0000 + i;
            it.a = ADDR_W'(i);
            it.l = (i == 3);
            sb.push_back(it);
        end
        for (int i = 0; i < 4; i++)
            wr(ADDR_W'(i), 32'hC0DE_0000 + i);
        wait_drained(40);
        chk("restart_busy", busy, 0);
        step();
        chk("restart_empty", entry_valid, 0);

        // Randomized drains with random backpressure, stray stores and ignored starts
        for (int t = 0; t < 25; t++) begin
            base = $urandom_range(0, DEPTH - 1);
            cnt  = $urandom_range(0, DEPTH);
            n    = (cnt == 0) ? DEPTH : cnt;
            for (int i = 0; i < n; i++)
                wr(ADDR_W'((base + i) % DEPTH), $urandom);
            start(base, cnt, n);
            for (int k = 0; k < 400 && sb.size() != 0; k++) begin
                rd_ready = ($urandom_range(0, 2) != 0);
                if (n < DEPTH && $urandom_range(0, 3) == 0) begin
                    off = n + $urandom_range(0, DEPTH - n - 1);
                    wr_en   = 1'b1;
                    wr_addr = ADDR_W'((base + off) % DEPTH);
                    wr_data = $urandom;
                    ref_mem[wr_addr] = wr_data;
                end
                if ($urandom_range(0, 7) == 0) begin
                    drain_start = 1'b1;
                    drain_base  = ADDR_W'($urandom);
                    drain_count = (ADDR_W+1)'($urandom_range(1, DEPTH));
                end
                step();
                wr_en = 1'b0;
                drain_start = 1'b0;
            end
            chk("rand_drain_timeout", sb.size() == 0, 1);
            chk("rand_busy_at_done", busy, 0);
            rd_ready = 1'b1;
            step();
            step();
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Receiving end of the accumulator's store interface: 16-entry x 32-bit buffer written through `wr_en`/`wr_addr`/`wr_data`.
- `wr_en`/`wr_addr`/`wr_data` connect directly to the accumulator's `output_buffer_enable`/`output_buffer_addr`/`output_data`.
- A drain engine reads a programmed range of entries out to the host over a valid/ready stream, clearing each entry as it is consumed.
- Sits between the systolic array's accumulator and the host read-back path.

Parameters:
- DATA_W, 32, width of a buffer entry and of the read stream.
- DEPTH, 16, number of entries; must equal 2**ADDR_W.
- ADDR_W, 4, address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  in  1  store strobe from the accumulator.
- wr_addr  in  ADDR_W  entry address for the store.
- wr_data  in  DATA_W  value to store.
- drain_start  in  1  one-cycle request to begin a drain; ignored while busy.
- drain_base  in  ADDR_W  first entry to drain, sampled with drain_start.
- drain_count  in  ADDR_W+1  entries to drain, sampled with drain_start; 0 means DEPTH.
- drain_abort  in  1  terminate the current drain.
- rd_valid  out  1  rd_data/rd_addr/rd_last are valid.
- rd_ready  in  1  host accepts the word.
- rd_data  out  DATA_W  drained entry value.
- rd_addr  out  ADDR_W  address of the drained entry.
- rd_last  out  1  final word of the drain.
- busy  out  1  drain in progress.
- done  out  1  one-cycle pulse when the last word is accepted.
- overwrite_err  out  1  one-cycle pulse when a store hits a still-valid entry.
- entry_valid  out  DEPTH  per-entry valid flags.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; entry_valid=0.
  - rd_valid, rd_last, busy, done and overwrite_err are 0.
  - rd_data=0, rd_addr=0.
  - Memory array contents are not reset.
- Store path:
  - When wr_en=1 at an edge, mem[wr_addr] is written with wr_data and entry_valid[wr_addr] is set.
  - Stores are accepted in every state, every cycle; there is no backpressure.
  - If entry_valid[wr_addr] was 1 and that entry is not being cleared by a handshake in the same cycle, overwrite_err=1 on the next cycle and the new data replaces the old.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - On drain_start=1: latch ptr=drain_base and remaining=(drain_count==0 ? DEPTH : drain_count), then go to FETCH.
  - busy=1 from the cycle after drain_start.
- FETCH:
  - If entry_valid[ptr]=1: register rd_data=mem[ptr], rd_addr=ptr, rd_last=(remaining==1), rd_valid=1, then go to SEND.
  - Otherwise stall in FETCH. A drain may be started before accumulation finishes.
  - A store to ptr in the same cycle is not seen until the next cycle, so fetch latency is one extra cycle.
- SEND:
  - rd_data, rd_addr and rd_last are held stable while rd_valid=1 && rd_ready=0, even if that entry is rewritten.
  - On rd_valid && rd_ready: clear entry_valid[ptr]. If a store to the same address occurs in that cycle, the store wins and valid stays 1.
  - Also on handshake: rd_valid=0; ptr=ptr+1 modulo DEPTH (wrap 15 -> 0); remaining decrements.
  - Then go to DONE if remaining was 1, else go to FETCH.
- Throughput: at most one word every 2 cycles.
- Latency from drain_start to first rd_valid is 2 cycles when the entry is already valid.
- DONE:
  - done=1 for one cycle, busy drops to 0 in the same cycle, rd_last returns to 0.
  - Then go to IDLE; a new drain_start is accepted in the following IDLE cycle.
- drain_abort:
  - In FETCH or SEND, the next state is IDLE; rd_valid, rd_last and busy become 0; no done pulse.
  - Entries not yet handshaken keep their valid flags.
  - drain_abort has priority over a simultaneous handshake: the entry is not cleared.
  - Ignored in IDLE and DONE.
- drain_start while busy is ignored; no queuing.
- Address width rule: DATA_W values pass through unmodified.

Test Plan:
- Reset then idle: rst=0 mid-SEND with rd_valid=1 -> all outputs 0 immediately, entry_valid=0 after release.
- Store then drain: write 0x11,0x22,0x33 at addr 2,3,4; drain_base=2, count=3, rd_ready=1 -> words 0x11,0x22,0x33 with rd_addr 2,3,4; rd_last only on 0x33; done pulse; entry_valid[4:2]=0.
- Wrap and backpressure: fill addr 14,15,0; drain_base=14, count=3; hold rd_ready=0 for 5 cycles on the first word -> rd_data=mem[14] stable throughout; order 14,15,0; done after third handshake.
- Early drain stall: drain_base=5, count=1 with entry 5 empty -> FSM stays in FETCH, rd_valid=0; write 0xABCD at addr 5 -> rd_valid rises 2 cycles after the write with rd_data=0xABCD.
- Overwrite and collision: write addr 7 twice without a drain -> overwrite_err pulse after the second write. Write addr 7 in the same cycle as its handshake -> entry_valid[7] stays 1, no overwrite_err.
- Abort and count=0: drain_count=0 from base 0 with all 16 entries valid, abort after 4 handshakes -> 4 entries cleared, 12 still valid, no done, busy=0. A restarted full drain then yields the remaining 12 words followed by 4 stalled FETCH cycles until those entries are rewritten.
